// File: rtl/p405s_br_pkg.sv
// Shared types and BO-field bit positions for the EXE branch-condition pipe.
// BO is numbered big-endian: bit 0 is the MSB of the 5-bit field.
package p405s_br_pkg;

  typedef enum logic [1:0] {
    BC    = 2'b00,
    BCLR  = 2'b01,
    BCCTR = 2'b10,
    RSVD  = 2'b11
  } br_kind_t;

  localparam int BO_WIDTH    = 5;
  localparam int BO_COND_IGN = 0;  // 1: ignore the CR bit
  localparam int BO_COND_VAL = 1;  // CR bit value that satisfies the condition
  localparam int BO_CTR_IGN  = 2;  // 1: CTR neither decremented nor tested
  localparam int BO_CTR_EQ   = 3;  // 1: branch when CTR reaches zero

  // Control part of a registered branch result; the CTR copy travels beside it.
  typedef struct packed {
    logic     taken;
    logic     cond_ok_n;
    br_kind_t kind;
    logic     illegal;
  } br_res_t;

  localparam br_res_t BR_RES_RESET = '{taken: 1'b0, cond_ok_n: 1'b1, kind: BC, illegal: 1'b0};

endpackage

// File: rtl/p405s_br_cond_eval.sv
// Combinational BO/BI evaluation: CR bit select, condition term, CTR decrement and test.
// Holds no state; the pipe registers everything this block produces.
module p405s_br_cond_eval
  import p405s_br_pkg::*;
#(
  parameter int CR_WIDTH  = 32,
  parameter int CTR_WIDTH = 32,
  parameter int BI_WIDTH  = $clog2(CR_WIDTH)
) (
  input  br_kind_t             kind_i,
  input  logic [0:BO_WIDTH-1]  bo_i,
  input  logic [0:BI_WIDTH-1]  bi_i,
  input  logic [0:CR_WIDTH-1]  cr_i,
  input  logic [0:CTR_WIDTH-1] ctr_i,
  output logic [0:CTR_WIDTH-1] ctr_next_o,
  output logic                 cond_ok_o,
  output logic                 ctr_ok_o,
  output logic                 illegal_o,
  output logic                 taken_o
);

  logic cr_bit;
  logic dec;
  logic ctr_zero;

  assign cr_bit    = cr_i[bi_i];
  assign cond_ok_o = bo_i[BO_COND_IGN] | (cr_bit ~^ bo_i[BO_COND_VAL]);

  // bcctr uses CTR as its target, so it never decrements it.
  assign dec        = ~bo_i[BO_CTR_IGN] & (kind_i != BCCTR);
  assign ctr_next_o = dec ? ctr_i - CTR_WIDTH'(1) : ctr_i;
  assign ctr_zero   = (ctr_next_o == '0);
  assign ctr_ok_o   = bo_i[BO_CTR_IGN] | (ctr_zero ~^ bo_i[BO_CTR_EQ]);

  assign illegal_o = (kind_i == RSVD) | ((kind_i == BCCTR) & ~bo_i[BO_CTR_IGN]);
  assign taken_o   = cond_ok_o & ctr_ok_o & ~illegal_o;

endmodule

// File: rtl/p405s_exe_br_cond_pipe.sv
// Registered branch-condition unit: one-cycle result with valid/ready handshake,
// speculative CTR updated at accept and architected CTR updated at retire or mtctr.
module p405s_exe_br_cond_pipe
  import p405s_br_pkg::*;
#(
  parameter int CR_WIDTH  = 32,
  parameter int CTR_WIDTH = 32,
  parameter int BI_WIDTH  = 5
) (
  input  logic                 CB,
  input  logic                 reset_Neg,
  input  logic                 exeBrVld,
  output logic                 exeBrRdy,
  input  logic [1:0]           exeBrKind,
  input  logic [0:4]           exeBOL2,
  input  logic [0:BI_WIDTH-1]  exeBIL2,
  input  logic [0:CR_WIDTH-1]  crL2,
  input  logic                 ctrWrEn,
  input  logic [0:CTR_WIDTH-1] ctrWrData,
  input  logic                 flush,
  output logic                 resVld,
  input  logic                 resRdy,
  output logic                 resTaken,
  output logic                 resCondOk_Neg,
  output logic [1:0]           resKind,
  output logic                 resIllegal,
  output logic [0:CTR_WIDTH-1] ctrSpec
);

  logic                 res_vld_q, res_vld_d;
  br_res_t              res_q, res_d;
  logic [0:CTR_WIDTH-1] res_ctr_q, res_ctr_d;
  logic [0:CTR_WIDTH-1] ctr_spec_q, ctr_spec_d;
  logic [0:CTR_WIDTH-1] ctr_arch_q, ctr_arch_d;

  logic                 accept;
  logic                 retire;
  logic [0:CTR_WIDTH-1] ctr_in;
  logic [0:CTR_WIDTH-1] ctr_next;
  logic                 cond_ok;
  logic                 ctr_ok;
  logic                 illegal;
  logic                 taken;

  assign exeBrRdy = ~res_vld_q | resRdy;
  assign accept   = exeBrVld & exeBrRdy & ~flush;
  assign retire   = res_vld_q & resRdy & ~flush;

  // A same-cycle mtctr is older than the branch, so the branch sees its data.
  assign ctr_in = ctrWrEn ? ctrWrData : ctr_spec_q;

  p405s_br_cond_eval #(
    .CR_WIDTH  (CR_WIDTH),
    .CTR_WIDTH (CTR_WIDTH),
    .BI_WIDTH  (BI_WIDTH)
  ) u_eval (
    .kind_i     (br_kind_t'(exeBrKind)),
    .bo_i       (exeBOL2),
    .bi_i       (exeBIL2),
    .cr_i       (crL2),
    .ctr_i      (ctr_in),
    .ctr_next_o (ctr_next),
    .cond_ok_o  (cond_ok),
    .ctr_ok_o   (ctr_ok),
    .illegal_o  (illegal),
    .taken_o    (taken)
  );

  // NOTE: every variable gets its hold value first, so no path through the
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    res_vld_d  = res_vld_q;
    res_d      = res_q;
    res_ctr_d  = res_ctr_q;
    ctr_spec_d = ctr_spec_q;
    ctr_arch_d = ctr_arch_q;

    if (flush) begin
      res_vld_d = 1'b0;
    end else if (accept) begin
      res_vld_d     = 1'b1;
      res_d.taken     = taken;
      res_d.cond_ok_n = ~cond_ok;
      res_d.kind      = br_kind_t'(exeBrKind);
      res_d.illegal   = illegal;
      res_ctr_d     = ctr_next;
    end else if (retire) begin
      res_vld_d = 1'b0;
    end

    // Speculative copy: flush rolls back to the architected value unless mtctr lands.
    if (flush) begin
      ctr_spec_d = ctrWrEn ? ctrWrData : ctr_arch_q;
    end else if (accept) begin
      ctr_spec_d = ctr_next;
    end else if (ctrWrEn) begin
      ctr_spec_d = ctrWrData;
    end

    // mtctr is non-speculative and younger than any retiring branch, so it wins.
    if (ctrWrEn) begin
      ctr_arch_d = ctrWrData;
    end else if (retire) begin
      ctr_arch_d = res_ctr_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CB or negedge reset_Neg) begin
    if (!reset_Neg) begin
      res_vld_q  <= 1'b0;
      res_q      <= BR_RES_RESET;
      res_ctr_q  <= '0;
      ctr_spec_q <= '0;
      ctr_arch_q <= '0;
    end else begin
      res_vld_q  <= res_vld_d;
      res_q      <= res_d;
      res_ctr_q  <= res_ctr_d;
      ctr_spec_q <= ctr_spec_d;
      ctr_arch_q <= ctr_arch_d;
    end
  end

  assign resVld        = res_vld_q;
  assign resTaken      = res_q.taken;
  assign resCondOk_Neg = res_q.cond_ok_n;
  assign resKind       = res_q.kind;
  assign resIllegal    = res_q.illegal;
  assign ctrSpec       = ctr_spec_q;

endmodule
